game_controller: RTL and testbench
==================================

Name: game_controller

Overview:
Top-level sequencer for the snake game.
- Drives the datapath through menu, screen clear, snake initialisation, play and game-over phases.
- Generates the frame tick and the snake-step pulse.
- Consumes collision flags from the datapath and keeps the score.
- Sits between the key/switch inputs and the datapath; replaces the constant-output fsm stub.

Parameters:
SCREEN_W, 160, pixel columns swept during clear
SCREEN_H, 120, pixel rows swept during clear
TICK_DIV, 840000, clk cycles per frame tick
STEP_FRAMES, 3, frame ticks per snake step
OVER_FRAMES, 120, frame ticks the game-over screen is held
SCORE_W, 8, score counter width

Ports:
clk  in  1  system clock (CLOCK_50)
resetn  in  1  asynchronous active-low reset
go  in  1  start request, active-high level, already synchronised
pause  in  1  level; freezes snake stepping while in PLAY
bad_collision  in  1  head hit border or body (datapath)
good_collision  in  1  head hit apple (datapath)
inmenu  out  1  high in MENU
ingame  out  1  high in PLAY and OVER
clear_en  out  1  high in CLEAR
clr_x  out  8  clear-sweep column
clr_y  out  7  clear-sweep row
init_snake  out  1  one-cycle pulse: datapath loads initial snake/apple
step  out  1  one-cycle pulse: datapath advances snake one cell
game_over  out  1  high in OVER
score  out  SCORE_W  apples eaten this game
plot  out  1  VGA write enable

Behaviour:
- Reset values:
  - state = MENU; inmenu = 1; every other output 0.
  - Score, clr_x/clr_y, step count and over count = 0.
  - Frame divider = TICK_DIV-1.
  - go_q = 1, so a go held through reset does not start a game.
- Frame tick:
  - Free-running down-counter; frame_tick is high for one cycle when it reaches 0, then reloads TICK_DIV-1.
  - Runs in all states.
- go edge: go_edge = go & ~go_q; go_q is registered every cycle.
- MENU:
  - go_edge → CLEAR next cycle; clr_x/clr_y = 0 and score cleared on entry.
- CLEAR:
  - One pixel per cycle; clr_x increments and wraps SCREEN_W-1→0, then clr_y increments.
  - On (SCREEN_W-1, SCREEN_H-1) → INIT next cycle.
  - Duration is exactly SCREEN_W*SCREEN_H cycles.
- INIT:
  - Lasts one cycle with init_snake = 1; step count cleared; → PLAY.
- PLAY:
  - The step counter increments on frame_tick while pause = 0.
  - On frame_tick with count == STEP_FRAMES-1, step = 1 for that cycle and the count wraps to 0.
  - pause = 1 holds the count and suppresses step; collisions are still honoured.
- Score:
  - Increments on the rising edge of good_collision (registered previous value), not on its level.
  - Saturates at 2^SCORE_W-1.
- bad_collision in PLAY → OVER next cycle; over count = 0.
- Simultaneous events in the same cycle:
  - bad_collision with good_collision: bad wins, score unchanged.
  - bad_collision with a step condition: step suppressed.
- OVER:
  - game_over = 1; the over count increments on frame_tick.
  - At OVER_FRAMES ticks → MENU.
  - go_edge is ignored in OVER.
  - Score is held through OVER and MENU until the next CLEAR entry.
- plot = 1 in every state except INIT.
- Collision inputs are ignored outside PLAY.
- Asynchronous reset in any state returns to the reset values immediately; there is no partial-state carry-over.
- Width rules:
  - clr_x is 8 bits and clr_y is 7 bits; both are compared against SCREEN_W-1 and SCREEN_H-1.
  - Divider width is clog2(TICK_DIV); step and over counter widths come from clog2 of their parameters.

Decomposition:
- Package snake_pkg:
  - State enum {MENU, CLEAR, INIT, PLAY, OVER}.
  - SCREEN_W/SCREEN_H defaults.
  - Direction one-hot codes shared with the datapath.
- Sub-module frame_tick_gen (parameter TICK_DIV; ports clk, resetn, frame_tick) is natural and reusable by the datapath.
- Everything else stays in one FSM module.

Test Plan:
All scenarios use parameters SCREEN_W=4, SCREEN_H=3, TICK_DIV=4, STEP_FRAMES=3, OVER_FRAMES=2.
1. Reset release with go held high → stays MENU (inmenu=1); go low for 1 cycle then high → CLEAR on next cycle.
2. go edge in MENU → clear_en high exactly 12 cycles; (clr_x, clr_y) walks (0,0),(1,0)…(3,2); then init_snake high 1 cycle; then ingame=1, inmenu=0.
3. PLAY, pause=0 → step pulses exactly every 12 cycles; pause=1 for 30 cycles → no step, and stepping resumes with the held count.
4. good_collision held high 5 cycles → score +1 only; two separate pulses → score 2; bad_collision and good_collision asserted in the same cycle → game_over next cycle, score unchanged, no step.
5. OVER → game_over high for 2 frame ticks, then MENU; a go pulse during OVER has no effect; score retained in MENU and cleared on the next CLEAR entry.
6. resetn asserted mid-CLEAR and mid-PLAY → asynchronously inmenu=1, all other outputs 0, score 0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game controller and datapath.
package snake_pkg;

    // Top-level game phases.
    typedef enum logic [2:0] {
        MENU  = 3'd0,
        CLEAR = 3'd1,
        INIT  = 3'd2,
        PLAY  = 3'd3,
        OVER  = 3'd4
    } state_e;

    // Default VGA adapter resolution.
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    // One-hot snake heading codes understood by the datapath.
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    // Counter width for a modulus n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame tick: one-cycle pulse every TICK_DIV clocks.
module frame_tick_gen
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 840000
) (
    input  logic clk,
    input  logic resetn,
    output logic frame_tick
);

    localparam int            DW     = cnt_w(TICK_DIV);
    localparam logic [DW-1:0] RELOAD = DW'(TICK_DIV - 1);

    logic [DW-1:0] div_cnt;

    // Count down to zero, pulse there, then reload.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)              div_cnt <= RELOAD;
        else if (div_cnt == '0)   div_cnt <= RELOAD;
        else                      div_cnt <= div_cnt - 1'b1;
    end

    assign frame_tick = (div_cnt == '0);

endmodule

// File: rtl/game_controller.sv
// Snake game sequencer: menu, screen clear, snake init, play, game over.
// Produces the datapath control strobes, the step pulse and the score.
module game_controller
    import snake_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int TICK_DIV    = 840000,
    parameter int STEP_FRAMES = 3,
    parameter int OVER_FRAMES = 120,
    parameter int SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               go,
    input  logic               pause,
    input  logic               bad_collision,
    input  logic               good_collision,
    output logic               inmenu,
    output logic               ingame,
    output logic               clear_en,
    output logic [7:0]         clr_x,
    output logic [6:0]         clr_y,
    output logic               init_snake,
    output logic               step,
    output logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic               plot
);

    localparam int         SW     = cnt_w(STEP_FRAMES);
    localparam int         OW     = cnt_w(OVER_FRAMES);
    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

    state_e        state, state_nx;
    logic          frame_tick;
    logic          go_q, good_q;
    logic          go_edge, good_rise;
    logic [SW-1:0] step_cnt;
    logic [OW-1:0] over_cnt;
    logic          step_due;
    logic          clr_last;

    frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_frame_tick (
        .clk        (clk),
        .resetn     (resetn),
        .frame_tick (frame_tick)
    );

    assign go_edge   = go & ~go_q;
    assign good_rise = good_collision & ~good_q;
    assign clr_last  = (clr_x == X_LAST) && (clr_y == Y_LAST);
    assign step_due  = frame_tick & ~pause & (step_cnt == SW'(STEP_FRAMES - 1));

    // Next phase; a collision always beats anything else in PLAY.
    always_comb begin
        state_nx = state;
        case (state)
            MENU:    if (go_edge) state_nx = CLEAR;
            CLEAR:   if (clr_last) state_nx = INIT;
            INIT:    state_nx = PLAY;
            PLAY:    if (bad_collision) state_nx = OVER;
            OVER:    if (frame_tick && over_cnt == OW'(OVER_FRAMES - 1)) state_nx = MENU;
            default: state_nx = MENU;
        endcase
    end

    // Phase register, input edge history and registered plot enable.
    // go_q resets high so a go held through reset is not seen as a press.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= MENU;
            go_q   <= 1'b1;
            good_q <= 1'b0;
            plot   <= 1'b0;
        end else begin
            state  <= state_nx;
            go_q   <= go;
            good_q <= good_collision;
            plot   <= (state_nx != INIT);
        end
    end

    // Clear sweep: raster order, one pixel per cycle, wraps back to origin.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clr_x <= '0;
            clr_y <= '0;
        end else if (state == MENU && go_edge) begin
            clr_x <= '0;
            clr_y <= '0;
        end else if (state == CLEAR) begin
            if (clr_x == X_LAST) begin
                clr_x <= '0;
                clr_y <= (clr_y == Y_LAST) ? '0 : clr_y + 7'd1;
            end else begin
                clr_x <= clr_x + 8'd1;
            end
        end
    end

    // Frames-per-step counter; frozen while paused.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            step_cnt <= '0;
        else if (state == INIT)
            step_cnt <= '0;
        else if (state == PLAY && frame_tick && !pause && !bad_collision)
            step_cnt <= step_due ? '0 : step_cnt + 1'b1;
    end

    // Game-over hold counter in frame ticks.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            over_cnt <= '0;
        else if (state == PLAY && bad_collision)
            over_cnt <= '0;
        else if (state == OVER && frame_tick)
            over_cnt <= over_cnt + 1'b1;
    end

    // Score: one point per apple edge, saturating; held until next clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            score <= '0;
        else if (state == MENU && go_edge)
            score <= '0;
        else if (state == PLAY && !bad_collision && good_rise && score != '1)
            score <= score + 1'b1;
    end

    assign inmenu     = (state == MENU);
    assign ingame     = (state == PLAY) || (state == OVER);
    assign clear_en   = (state == CLEAR);
    assign init_snake = (state == INIT);
    assign game_over  = (state == OVER);
    assign step       = (state == PLAY) && step_due && !bad_collision;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller with a phase-level reference model.
module tb_game_controller;

    localparam int W = 4, H = 3, TD = 4, SF = 3, OF = 2;
    localparam int P_MENU = 0, P_CLEAR = 1, P_INIT = 2, P_PLAY = 3, P_OVER = 4;
    // snapshot vector layout
    localparam int B_OVER = 9, B_STEP = 10, B_INIT = 11, B_CLR = 27, B_GAME = 28, B_MENU = 29;
    localparam logic [29:0] RST_VEC = 30'h2000_0000;

    logic clk = 1'b0, resetn = 1'b0, go = 1'b0, pause = 1'b0, bad = 1'b0, good = 1'b0;
    logic inmenu, ingame, clear_en, init_snake, step, game_over, plot;
    logic [7:0] clr_x, score;
    logic [6:0] clr_y;

    always #5 clk = ~clk;

    game_controller #(
        .SCREEN_W(W), .SCREEN_H(H), .TICK_DIV(TD),
        .STEP_FRAMES(SF), .OVER_FRAMES(OF), .SCORE_W(8)
    ) dut (
        .clk(clk), .resetn(resetn), .go(go), .pause(pause),
        .bad_collision(bad), .good_collision(good),
        .inmenu(inmenu), .ingame(ingame), .clear_en(clear_en),
        .clr_x(clr_x), .clr_y(clr_y), .init_snake(init_snake),
        .step(step), .game_over(game_over), .score(score), .plot(plot)
    );

    int tests = 0, fails = 0;

    // reference model state
    int m_phase, m_cyc, m_idx, m_ticks, m_over, m_score;
    bit m_go_prev, m_good_prev;
    logic [29:0] exp_q, dut_q;

    function automatic logic [29:0] dut_vec();
        return {inmenu, ingame, clear_en, clr_x, clr_y, init_snake, step, game_over, score, plot};
    endfunction

    function automatic bit m_tick();
        return (m_cyc % TD) == TD - 1;
    endfunction

    function automatic bit m_step(bit p, bit b);
        return m_phase == P_PLAY && m_tick() && !p && !b && (m_ticks % SF) == SF - 1;
    endfunction

    function automatic logic [29:0] model_vec();
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] s;
        bit pl;
        x  = 8'(m_idx % W);
        y  = 7'(m_idx / W);
        s  = 8'(m_score);
        pl = (m_cyc > 0) && (m_phase != P_INIT);
        return {m_phase == P_MENU, (m_phase == P_PLAY || m_phase == P_OVER), m_phase == P_CLEAR,
                x, y, m_phase == P_INIT, m_step(pause, bad), m_phase == P_OVER, s, pl};
    endfunction

    task automatic model_reset();
        m_phase = P_MENU; m_cyc = 0; m_idx = 0; m_ticks = 0; m_over = 0; m_score = 0;
        m_go_prev = 1'b1; m_good_prev = 1'b0;
    endtask

    task automatic model_update();
        bit t, ge, gr;
        t  = m_tick();
        ge = go && !m_go_prev;
        gr = good && !m_good_prev;
        case (m_phase)
            P_MENU:  if (ge) begin m_phase = P_CLEAR; m_idx = 0; m_score = 0; end
            P_CLEAR: begin
                m_idx++;
                if (m_idx == W * H) begin m_idx = 0; m_phase = P_INIT; end
            end
            P_INIT:  begin m_ticks = 0; m_phase = P_PLAY; end
            P_PLAY:  if (bad) begin m_phase = P_OVER; m_over = 0; end
                     else begin
                         if (gr && m_score < 255) m_score++;
                         if (t && !pause) m_ticks++;
                     end
            P_OVER:  if (t) begin m_over++; if (m_over == OF) m_phase = P_MENU; end
            default: m_phase = P_MENU;
        endcase
        m_go_prev = go; m_good_prev = good; m_cyc++;
    endtask

    // Called just after a falling edge with inputs set: snapshot, then one clock.
    task automatic cycle();
        #1;
        exp_q = model_vec();
        dut_q = dut_vec();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0; go = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        tests++; if (dut_vec() !== RST_VEC) begin fails++; $display("FAIL reset_values got=%h exp=%h", dut_vec(), RST_VEC); end
        @(negedge clk);
        resetn = 1'b1; model_reset();
        for (int i = 0; i < 6; i++) begin
            cycle();
            tests++; if (dut_q !== exp_q) begin fails++; $display("FAIL reset_hold_go got=%h exp=%h", dut_q, exp_q); end
        end
        tests++; if (dut_q[B_MENU] !== 1'b1) begin fails++; $display("FAIL menu_with_go_held got=%b exp=1", dut_q[B_MENU]); end
        go = 1'b0; cycle();
        tests++; if (dut_q !== exp_q) begin fails++; $display("FAIL go_low got=%h exp=%h", dut_q, exp_q); end
        go = 1'b1; cycle();
        tests++; if (dut_q !== exp_q) begin fails++; $display("FAIL go_edge got=%h exp=%h", dut_q, exp_q); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < W * H; i++) begin
            cycle();
            tests++; if (dut_q !== exp_q) begin fails++; $display("FAIL clear_lockstep got=%h exp=%h", dut_q, exp_q); end
            tests++;
            if (dut_q[B_CLR] !== 1'b1 || dut_q[26:19] !== 8'(i % W) || dut_q[18:12] !== 7'(i / W)) begin
                fails++; $display("FAIL clear_walk i=%0d got en=%b x=%0d y=%0d exp en=1 x=%0d y=%0d",
                                  i, dut_q[B_CLR], dut_q[26:19], dut_q[18:12], i % W, i / W);
            end
        end
        cycle();
        tests++; if (dut_q[B_INIT] !== 1'b1 || dut_q[B_CLR] !== 1'b0) begin
            fails++; $display("FAIL init_pulse got init=%b clr=%b exp init=1 clr=0", dut_q[B_INIT], dut_q[B_CLR]); end
        cycle();
        tests++; if (dut_q[B_GAME] !== 1'b1 || dut_q[B_MENU] !== 1'b0 || dut_q[B_INIT] !== 1'b0) begin
            fails++; $display("FAIL enter_play got ingame=%b inmenu=%b init=%b exp 1 0 0", dut_q[B_GAME], dut_q[B_MENU], dut_q[B_INIT]); end
    endtask

    task automatic test_step();
        int last, cnt;
        bit seen;
        last = -1;
        pause = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            tests++; if (dut_q !== exp_q) begin fails++; $display("FAIL step_lockstep got=%h exp=%h", dut_q, exp_q); end
            if (dut_q[B_STEP]) begin
                if (last >= 0) begin
                    tests++; if (i - last !== 12) begin fails++; $display("FAIL step_period got=%0d exp=12", i - last); end
                end
                last = i;
            end
        end
        pause = 1'b1; cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            tests++; if (dut_q !== exp_q) begin fails++; $display("FAIL pause_lockstep got=%h exp=%h", dut_q, exp_q); end
            if (dut_q[B_STEP]) cnt++;
        end
        tests++; if (cnt !== 0) begin fails++; $display("FAIL pause_no_step got=%0d steps exp=0", cnt); end
        pause = 1'b0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle();
            tests++; if (dut_q !== exp_q) begin fails++; $display("FAIL resume_lockstep got=%h exp=%h", dut_q, exp_q); end
            seen = dut_q[B_STEP];
        end
        tests++; if (!seen) begin fails++; $display("FAIL resume_step got=none exp=step within 40 cycles"); end
        for (int i = 0; i < 60; i++) begin
            pause = ($urandom_range(0, 3) == 0);
            cycle();
            tests++; if (dut_q !== exp_q) begin fails++; $display("FAIL rand_pause_lockstep got=%h exp=%h", dut_q, exp_q); end
        end
        pause = 1'b0;
    endtask

    task automatic test_score();
        int base, saved;
        bit found;
        base = m_score;
        good = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            tests++; if (dut_q !== exp_q) begin fails++; $display("FAIL good_held_lockstep got=%h exp=%h", dut_q, exp_q); end
        end
        good = 1'b0; cycle(); cycle();
        tests++; if (dut_q[8:1] !== 8'(base + 1)) begin fails++; $display("FAIL good_level got=%0d exp=%0d", dut_q[8:1], base + 1); end
        for (int p = 0; p < 2; p++) begin
            good = 1'b1; cycle();
            good = 1'b0; cycle(); cycle();
            tests++; if (dut_q !== exp_q) begin fails++; $display("FAIL good_pulse_lockstep got=%h exp=%h", dut_q, exp_q); end
        end
        tests++; if (dut_q[8:1] !== 8'(base + 3)) begin fails++; $display("FAIL good_pulses got=%0d exp=%0d", dut_q[8:1], base + 3); end
        for (int i = 0; i < 40; i++) begin
            good  = $urandom_range(0, 1);
            pause = ($urandom_range(0, 4) == 0);
            cycle();
            tests++; if (dut_q !== exp_q) begin fails++; $display("FAIL rand_good_lockstep got=%h exp=%h", dut_q, exp_q); end
        end
        good = 1'b0; pause = 1'b0; found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_step(1'b0, 1'b0) && !m_good_prev) begin
                saved = m_score;
                bad = 1'b1; good = 1'b1;
                cycle();
                tests++; if (dut_q[B_STEP] !== 1'b0) begin fails++; $display("FAIL bad_kills_step got=%b exp=0", dut_q[B_STEP]); end
                bad = 1'b0; good = 1'b0;
                cycle();
                tests++; if (dut_q[B_OVER] !== 1'b1 || dut_q[8:1] !== 8'(saved)) begin
                    fails++; $display("FAIL bad_beats_good got over=%b score=%0d exp over=1 score=%0d", dut_q[B_OVER], dut_q[8:1], saved); end
                found = 1'b1;
            end else begin
                cycle();
                tests++; if (dut_q !== exp_q) begin fails++; $display("FAIL seek_step_lockstep got=%h exp=%h", dut_q, exp_q); end
            end
        end
        tests++; if (!found) begin fails++; $display("FAIL collide_timeout got=no step slot exp=slot within 40 cycles"); end
    endtask

    task automatic test_over();
        int saved, tk;
        bit t;
        saved = m_score; tk = 0;
        for (int i = 0; i < 30 && m_phase == P_OVER; i++) begin
            go = (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            bad = $urandom_range(0, 1); good = $urandom_range(0, 1);
            t = m_tick();
            cycle();
            tests++; if (dut_q !== exp_q) begin fails++; $display("FAIL over_lockstep got=%h exp=%h", dut_q, exp_q); end
            if (dut_q[B_OVER] && t) tk++;
        end
        bad = 1'b0; good = 1'b0;
        tests++; if (tk !== OF) begin fails++; $display("FAIL over_ticks got=%0d exp=%0d", tk, OF); end
        go = 1'b0; cycle();
        tests++; if (dut_q[B_MENU] !== 1'b1 || dut_q[8:1] !== 8'(saved)) begin
            fails++; $display("FAIL menu_keeps_score got menu=%b score=%0d exp menu=1 score=%0d", dut_q[B_MENU], dut_q[8:1], saved); end
        go = 1'b1; cycle();
        cycle();
        tests++; if (dut_q[B_CLR] !== 1'b1 || dut_q[8:1] !== 8'd0) begin
            fails++; $display("FAIL clear_resets_score got clr=%b score=%0d exp clr=1 score=0", dut_q[B_CLR], dut_q[8:1]); end
        for (int i = 0; i < 4; i++) begin
            cycle();
            tests++; if (dut_q !== exp_q) begin fails++; $display("FAIL clear2_lockstep got=%h exp=%h", dut_q, exp_q); end
        end
    endtask

    task automatic test_async_reset(input int where);
        #3;
        resetn = 1'b0;
        #1;
        tests++; if (dut_vec() !== RST_VEC) begin fails++; $display("FAIL async_reset_%0d got=%h exp=%h", where, dut_vec(), RST_VEC); end
        @(negedge clk);
        tests++; if (dut_vec() !== RST_VEC) begin fails++; $display("FAIL reset_held_%0d got=%h exp=%h", where, dut_vec(), RST_VEC); end
        resetn = 1'b1; model_reset();
    endtask

    task automatic test_saturate();
        go = 1'b0; cycle();
        go = 1'b1;
        for (int i = 0; i < 40 && m_phase != P_PLAY; i++) begin
            cycle();
            tests++; if (dut_q !== exp_q) begin fails++; $display("FAIL restart_lockstep got=%h exp=%h", dut_q, exp_q); end
        end
        tests++; if (m_phase != P_PLAY) begin fails++; $display("FAIL restart_timeout got=phase %0d exp=play", m_phase); end
        pause = 1'b1;
        for (int i = 0; i < 260; i++) begin
            good = 1'b1; cycle();
            good = 1'b0; cycle();
            tests++; if (dut_q !== exp_q) begin fails++; $display("FAIL saturate_lockstep got=%h exp=%h", dut_q, exp_q); end
        end
        cycle();
        tests++; if (dut_q[8:1] !== 8'd255) begin fails++; $display("FAIL score_saturates got=%0d exp=255", dut_q[8:1]); end
        pause = 1'b0;
        for (int i = 0; i < 7; i++) cycle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clear();
        test_step();
        test_score();
        test_over();
        test_async_reset(0);
        test_saturate();
        test_async_reset(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
